// File: rtl/lhn_mult_pkg.sv
// Shared definitions for the pipelined shift-add multiplier.
//   MW_DEF / QW_DEF : default multiplicand / multiplier widths
//   PW              : default product width (MW_DEF + QW_DEF)
//   prod_w/stage_w  : width helpers for arbitrary MW/QW
// A stage record is packed as {valid, M, ph, mpl}, msb first.
package lhn_mult_pkg;

  localparam int unsigned MW_DEF = 7;
  localparam int unsigned QW_DEF = 4;
  localparam int unsigned PW     = MW_DEF + QW_DEF;

  function automatic int unsigned prod_w(input int unsigned mw, input int unsigned qw);
    return mw + qw;
  endfunction

  // {valid, M, ph, mpl}
  function automatic int unsigned stage_w(input int unsigned mw, input int unsigned qw);
    return 1 + mw + mw + qw;
  endfunction

endpackage

// File: rtl/lhn_mult_step.sv
// One combinational shift-add step.
//   m, ph, mpl  : current stage multiplicand, partial-high, multiplier/low bits
//   last_step   : stage handles the multiplier msb (used in signed mode only)
//   ph_nx, mpl_nx : next-stage partial-high and low bits
// Macro LHN_PIPE_MULT_SIGNED_EN selects two's complement operation.
module lhn_mult_step
  import lhn_mult_pkg::*;
#(
  parameter int unsigned MW = MW_DEF,
  parameter int unsigned QW = QW_DEF
) (
  input  logic [MW-1:0] m,
  input  logic [MW-1:0] ph,
  input  logic [QW-1:0] mpl,
  input  logic          last_step,
  output logic [MW-1:0] ph_nx,
  output logic [QW-1:0] mpl_nx
);

  logic [MW:0] pp;
  logic [MW:0] sum;

`ifdef LHN_PIPE_MULT_SIGNED_EN
  // The multiplier msb carries negative weight, so the last step subtracts.
  always_comb begin
    pp  = mpl[0] ? {m[MW-1], m} : '0;
    sum = last_step ? ({ph[MW-1], ph} - pp) : ({ph[MW-1], ph} + pp);
  end
`else
  logic unused_last_step;
  assign unused_last_step = last_step;

  always_comb begin
    pp  = mpl[0] ? {1'b0, m} : '0;
    sum = {1'b0, ph} + pp;
  end
`endif

  // sum[MW] is the carry (unsigned) or the sign (signed) of the wide sum.
  assign ph_nx  = sum[MW:1];
  assign mpl_nx = {sum[0], mpl[QW-1:1]};

endmodule

// File: rtl/lhn_pipe_mult.sv
// Fully pipelined MW x QW shift-add multiplier, QW+1 register stages.
//   clock, Rst_n         : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (M_in, mpl_in)
//   out_valid / out_ready: product handshake
//   product              : {ph, mpl} of the final stage, MW+QW bits
// Global stall: every stage advances only when the output slot is empty
// or being consumed. Define LHN_PIPE_MULT_SIGNED_EN for two's complement.
module lhn_pipe_mult
  import lhn_mult_pkg::*;
#(
  parameter int unsigned MW = MW_DEF,
  parameter int unsigned QW = QW_DEF
) (
  input  logic             clock,
  input  logic             Rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MW-1:0]    M_in,
  input  logic [QW-1:0]    mpl_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MW+QW-1:0] product
);

  localparam int unsigned SW = stage_w(MW, QW);

  logic [SW-1:0] stage_q [QW+1];
  logic [SW-1:0] stage_d [QW+1];
  logic [MW-1:0] ph_nx   [QW];
  logic [QW-1:0] mpl_nx  [QW];
  logic          adv;
  logic [MW-1:0] unused_m_last;

  for (genvar k = 0; k < QW; k++) begin : g_step
    localparam bit LAST = (k == int'(QW) - 1);
    lhn_mult_step #(
      .MW(MW),
      .QW(QW)
    ) u_step (
      .m        (stage_q[k][SW-2 -: MW]),
      .ph       (stage_q[k][MW+QW-1 -: MW]),
      .mpl      (stage_q[k][QW-1:0]),
      .last_step(LAST),
      .ph_nx    (ph_nx[k]),
      .mpl_nx   (mpl_nx[k])
    );
  end

  assign adv           = !stage_q[QW][SW-1] | out_ready;
  assign in_ready      = adv;
  assign out_valid     = stage_q[QW][SW-1];
  assign product       = stage_q[QW][MW+QW-1:0];
  assign unused_m_last = stage_q[QW][SW-2 -: MW];

  always_comb begin
    stage_d = stage_q;
    if (adv) begin
      // Bubbles load zero operands so idle input values never enter the pipe.
      stage_d[0] = {in_valid, M_in & {MW{in_valid}}, {MW{1'b0}}, mpl_in & {QW{in_valid}}};
      for (int unsigned k = 0; k < QW; k++) begin
        stage_d[k+1] = {stage_q[k][SW-1 -: 1+MW], ph_nx[k], mpl_nx[k]};
      end
    end
  end

  always_ff @(posedge clock or negedge Rst_n) begin
    if (!Rst_n) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: tb/tb_lhn_pipe_mult.sv
module tb_lhn_pipe_mult;

  logic clock = 1'b0;
  logic Rst_n;
  always #5 clock = ~clock;

  // Instance A: default 7x4
  logic        a_iv, a_ir, a_ov, a_or;
  logic [6:0]  a_m;
  logic [3:0]  a_q;
  logic [10:0] a_p;
  // Instance B: 12x9 random sweep
  logic        b_iv, b_ir, b_ov, b_or;
  logic [11:0] b_m;
  logic [8:0]  b_q;
  logic [20:0] b_p;

  lhn_pipe_mult #(.MW(7), .QW(4)) u_dut_a (
    .clock(clock), .Rst_n(Rst_n), .in_valid(a_iv), .in_ready(a_ir),
    .M_in(a_m), .mpl_in(a_q), .out_valid(a_ov), .out_ready(a_or), .product(a_p)
  );

  lhn_pipe_mult #(.MW(12), .QW(9)) u_dut_b (
    .clock(clock), .Rst_n(Rst_n), .in_valid(b_iv), .in_ready(b_ir),
    .M_in(b_m), .mpl_in(b_q), .out_valid(b_ov), .out_ready(b_or), .product(b_p)
  );

  int total = 0;
  int bad   = 0;

  logic [10:0] a_exp[$];
  int          a_acc[$];
  int          a_popc[$];
  int          a_cyc = 0;
  int          a_lat = 0;
  bit          a_hold = 0;
  logic [10:0] a_hold_p;

  logic [20:0] b_exp[$];
  int          b_pops = 0;
  bit          b_hold = 0;
  logic [20:0] b_hold_p;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer product, truncated to MW+QW bits.
  function automatic logic [63:0] ref_mul(input logic [63:0] m, input logic [63:0] q,
                                          input int mw, input int qw);
    longint sm, sq;
    sm = longint'(m);
    sq = longint'(q);
`ifdef LHN_PIPE_MULT_SIGNED_EN
    if (m[mw-1]) sm -= longint'(1) << mw;
    if (q[qw-1]) sq -= longint'(1) << qw;
`endif
    return 64'(sm * sq) & ((64'd1 << (mw + qw)) - 64'd1);
  endfunction

  // Called at a negedge; drives inputs, scores the handshakes of the coming edge.
  task automatic a_drive(input bit v, input logic [6:0] m, input logic [3:0] q, input bit r);
    a_iv = v; a_m = m; a_q = q; a_or = r;
    #1;
    if (a_hold) begin
      check("a_hold_valid", 64'(a_ov), 64'd1);
      check("a_hold_product", 64'(a_p), 64'(a_hold_p));
    end
    a_hold   = a_ov && !a_or;
    a_hold_p = a_p;
    if (a_ov && a_or) begin
      check("a_out_expected", 64'(a_exp.size() != 0), 64'd1);
      if (a_exp.size() != 0) begin
        check("a_product", 64'(a_p), 64'(a_exp.pop_front()));
        a_lat = a_cyc - a_acc.pop_front();
        a_popc.push_back(a_cyc);
      end
    end
    if (a_iv && a_ir) begin
      a_exp.push_back(11'(ref_mul(64'(m), 64'(q), 7, 4)));
      a_acc.push_back(a_cyc);
    end
    a_cyc++;
    @(negedge clock);
  endtask

  task automatic b_drive(input bit v, input logic [11:0] m, input logic [8:0] q, input bit r);
    b_iv = v; b_m = m; b_q = q; b_or = r;
    #1;
    if (b_hold) begin
      check("b_hold_valid", 64'(b_ov), 64'd1);
      check("b_hold_product", 64'(b_p), 64'(b_hold_p));
    end
    b_hold   = b_ov && !b_or;
    b_hold_p = b_p;
    if (b_ov && b_or) begin
      check("b_out_expected", 64'(b_exp.size() != 0), 64'd1);
      if (b_exp.size() != 0) begin
        check("b_product", 64'(b_p), 64'(b_exp.pop_front()));
        b_pops++;
      end
    end
    if (b_iv && b_ir) b_exp.push_back(21'(ref_mul(64'(m), 64'(q), 12, 9)));
    @(negedge clock);
  endtask

  function automatic logic [11:0] pick_m();
    case ($urandom_range(0, 5))
      0:       return 12'h000;
      1:       return 12'hFFF;
      2:       return 12'h800;
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic logic [8:0] pick_q();
    case ($urandom_range(0, 5))
      0:       return 9'h000;
      1:       return 9'h1FF;
      2:       return 9'h100;
      default: return 9'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0;
    a_iv = 0; a_m = '0; a_q = '0; a_or = 0;
    b_iv = 0; b_m = '0; b_q = '0; b_or = 0;
    repeat (2) @(negedge clock);

    // Reset state
    check("rst_a_out_valid", 64'(a_ov), 64'd0);
    check("rst_a_product", 64'(a_p), 64'd0);
    check("rst_a_in_ready", 64'(a_ir), 64'd1);
    check("rst_b_out_valid", 64'(b_ov), 64'd0);
    Rst_n = 1'b1;
    @(negedge clock);

    // Single op, latency QW+1
    a_drive(1, 7'd127, 4'd15, 1);
    for (int i = 0; i < 4; i++) begin
      check("t1_not_yet", 64'(a_ov), 64'd0);
      a_drive(0, '0, '0, 1);
    end
    check("t1_valid", 64'(a_ov), 64'd1);
    check("t1_product", 64'(a_p), ref_mul(64'd127, 64'd15, 7, 4));
    a_drive(0, '0, '0, 1);
    check("t1_latency", 64'(a_lat), 64'd5);
    check("t1_drop", 64'(a_ov), 64'd0);

    // Back-to-back stream
    a_popc.delete();
    a_drive(1, 7'd3, 4'd5, 1);
    a_drive(1, 7'd0, 4'd9, 1);
    a_drive(1, 7'd127, 4'd1, 1);
    a_drive(1, 7'd64, 4'd8, 1);
    repeat (8) a_drive(0, '0, '0, 1);
    check("t2_count", 64'(a_popc.size()), 64'd4);
    if (a_popc.size() == 4) check("t2_consecutive", 64'(a_popc[3] - a_popc[0]), 64'd3);
    check("t2_empty", 64'(a_exp.size()), 64'd0);

    // Backpressure
    a_drive(1, 7'd5, 4'd3, 1);
    a_drive(1, 7'd9, 4'd2, 1);
    a_drive(1, 7'd100, 4'd15, 1);
    for (int i = 0; i < 10 && !a_ov; i++) a_drive(0, '0, '0, 1);
    check("t3_reach", 64'(a_ov), 64'd1);
    for (int i = 0; i < 3; i++) begin
      a_drive(1, 7'd1, 4'd1, 0);
      check("t3_in_ready", 64'(a_ir), 64'd0);
    end
    repeat (10) a_drive(0, '0, '0, 1);
    check("t3_empty", 64'(a_exp.size()), 64'd0);

    // Reset mid-flight with two ops accepted
    a_drive(1, 7'd5, 4'd6, 1);
    a_drive(1, 7'd7, 4'd7, 1);
    Rst_n = 1'b0;
    #1;
    check("t4_rst_valid", 64'(a_ov), 64'd0);
    check("t4_rst_product", 64'(a_p), 64'd0);
    check("t4_rst_in_ready", 64'(a_ir), 64'd1);
    a_exp.delete(); a_acc.delete(); a_hold = 0;
    @(negedge clock);
    Rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t4_no_ghost", 64'(a_ov), 64'd0);
      a_drive(0, '0, '0, 1);
    end
    a_drive(1, 7'd2, 4'd3, 1);
    repeat (4) a_drive(0, '0, '0, 1);
    check("t4_new_valid", 64'(a_ov), 64'd1);
    check("t4_new_product", 64'(a_p), 64'd6);
    a_drive(0, '0, '0, 1);
    check("t4_latency", 64'(a_lat), 64'd5);

    // Reset while a stalled result sits at the output
    repeat (6) a_drive(1, 7'd100, 4'd13, 0);
    check("t4b_full", 64'(a_ov), 64'd1);
    Rst_n = 1'b0;
    #1;
    check("t4b_rst_valid", 64'(a_ov), 64'd0);
    check("t4b_rst_product", 64'(a_p), 64'd0);
    check("t4b_rst_in_ready", 64'(a_ir), 64'd1);
    a_exp.delete(); a_acc.delete(); a_hold = 0;
    @(negedge clock);
    Rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t4b_no_ghost", 64'(a_ov), 64'd0);
      a_drive(0, '0, '0, 1);
    end

    // Sign-sensitive constants
    a_drive(1, 7'h7F, 4'h7, 1);
    repeat (4) a_drive(0, '0, '0, 1);
`ifdef LHN_PIPE_MULT_SIGNED_EN
    check("t5_neg1x7", 64'(a_p), 64'h7F9);
`else
    check("t5_127x7", 64'(a_p), 64'h379);
`endif
    a_drive(0, '0, '0, 1);
    a_drive(1, 7'h40, 4'h8, 1);
    repeat (4) a_drive(0, '0, '0, 1);
    check("t5_40x8", 64'(a_p), 64'h200);
    a_drive(0, '0, '0, 1);
    check("t5_empty", 64'(a_exp.size()), 64'd0);

    // Random sweep at 12x9
    for (int i = 0; i < 3000; i++) begin
      b_drive($urandom_range(0, 9) < 7, pick_m(), pick_q(), $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 40 && b_exp.size() != 0; i++) b_drive(0, '0, '0, 1);
    check("b_drained", 64'(b_exp.size()), 64'd0);
    check("b_some_results", 64'(b_pops > 500), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
